// File: rtl/timer_ctrl.sv
// Control and interrupt sequencer for a 64-bit timer: prescaled count enable, debug halt,
// clear strobe on disable, and a sticky, maskable compare interrupt.
module timer_ctrl #(
    parameter int DIV_MAX = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        timer_en,
    input  logic        div_en,
    input  logic [3:0]  div_val,
    input  logic        dbg_mode,
    input  logic        halt_req,
    input  logic [63:0] cmp,
    input  logic        int_en,
    input  logic        int_st_clr,
    input  logic [63:0] cnt,
    output logic        cnt_en,
    output logic        cnt_clr,
    output logic        halt_ack,
    output logic        int_st,
    output logic        tim_int
);

    localparam logic [3:0] DIV_MAX_V = 4'(DIV_MAX);

    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

    state_t             state;
    logic [DIV_MAX-1:0] pcnt;
    logic [DIV_MAX-1:0] mask;
    logic [3:0]         e;
    logic               div_en_q;
    logic [3:0]         div_val_q;
    logic               div_chg;
    logic               tick;
    logic               match_q;
    logic               halt_hit;

    // NOTE: every variable gets a default before any condition, so no latch is inferred.
    always_comb begin
        e    = '0;
        mask = '0;
        if (div_en) begin
            e = (div_val > DIV_MAX_V) ? DIV_MAX_V : div_val;
        end
        for (int i = 0; i < DIV_MAX; i++) begin
            mask[i] = (i < int'(e));
        end
        // Any edit to the divider fields restarts the divide period and suppresses this tick.
        div_chg = (div_en != div_en_q) || (div_val != div_val_q);
        tick    = !div_chg && ((e == 4'd0) || (pcnt == mask));
    end

    assign halt_hit = dbg_mode & halt_req;
    assign cnt_en   = (state == RUN) && tick;
    assign halt_ack = (state == HALT);
    assign tim_int  = int_st & int_en;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pcnt      <= '0;
            div_en_q  <= 1'b0;
            div_val_q <= '0;
            match_q   <= 1'b0;
            int_st    <= 1'b0;
            cnt_clr   <= 1'b0;
        end else begin
            div_en_q  <= div_en;
            div_val_q <= div_val;
            match_q   <= (cnt == cmp);
            cnt_clr   <= 1'b0;

            // A new match outranks a simultaneous write-1-to-clear.
            if (match_q) begin
                int_st <= 1'b1;
            end else if (int_st_clr) begin
                int_st <= 1'b0;
            end

            case (state)
                IDLE: begin
                    pcnt <= '0;
                    if (timer_en) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (!timer_en) begin
                        state   <= IDLE;
                        pcnt    <= '0;
                        cnt_clr <= 1'b1;
                    end else begin
                        if (halt_hit) begin
                            state <= HALT;
                        end
                        pcnt <= (div_chg || tick) ? '0 : pcnt + DIV_MAX'(1);
                    end
                end
                HALT: begin
                    if (!timer_en) begin
                        state   <= IDLE;
                        pcnt    <= '0;
                        cnt_clr <= 1'b1;
                    end else begin
                        if (!halt_hit) begin
                            state <= RUN;
                        end
                        if (div_chg) begin
                            pcnt <= '0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    pcnt  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_timer_ctrl.sv
// Bench for timer_ctrl: a stand-in 64-bit counter plus a cycle-level reference model
// built from the timer's rules (run/halt flags, cycles-since-restart, modulo prescale).
module tb_timer_ctrl;

    localparam int DIV_MAX = 8;

    logic        clk        = 1'b0;
    logic        rst_n      = 1'b1;
    logic        timer_en   = 1'b0;
    logic        div_en     = 1'b0;
    logic [3:0]  div_val    = 4'd0;
    logic        dbg_mode   = 1'b0;
    logic        halt_req   = 1'b0;
    logic [63:0] cmp        = '1;
    logic        int_en     = 1'b0;
    logic        int_st_clr = 1'b0;
    logic [63:0] cnt;
    logic        cnt_en, cnt_clr, halt_ack, int_st, tim_int;

    logic        load     = 1'b0;
    logic [63:0] load_val = '0;

    int checks = 0;
    int errors = 0;

    timer_ctrl #(.DIV_MAX(DIV_MAX)) dut (
        .clk(clk), .rst_n(rst_n), .timer_en(timer_en), .div_en(div_en), .div_val(div_val),
        .dbg_mode(dbg_mode), .halt_req(halt_req), .cmp(cmp), .int_en(int_en),
        .int_st_clr(int_st_clr), .cnt(cnt), .cnt_en(cnt_en), .cnt_clr(cnt_clr),
        .halt_ack(halt_ack), .int_st(int_st), .tim_int(tim_int)
    );

    always #5 clk = ~clk;

    // Counter datapath stand-in, with a preload port for the bench.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)       cnt <= '0;
        else if (load)    cnt <= load_val;
        else if (cnt_clr) cnt <= '0;
        else if (cnt_en)  cnt <= cnt + 64'd1;
    end

    // Reference model state.
    bit          m_run, m_halt, m_clr, m_match, m_int, m_pen;
    logic [3:0]  m_pval;
    int          m_since;
    logic [63:0] m_cnt;
    int          e_eff, n_since;
    bit          chg, exp_cnt_en, n_run, n_halt;

    always_comb begin
        e_eff = 0;
        if (div_en) e_eff = (int'(div_val) > DIV_MAX) ? DIV_MAX : int'(div_val);
        chg        = (div_en != m_pen) || (div_val != m_pval);
        exp_cnt_en = m_run && !m_halt && !chg && (((m_since + 1) % (1 << e_eff)) == 0);
        n_run      = timer_en;
        n_halt     = m_run && timer_en && dbg_mode && halt_req;
        if (!n_run || chg)        n_since = 0;
        else if (m_run && !m_halt) n_since = m_since + 1;
        else                      n_since = m_since;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_run <= 1'b0; m_halt <= 1'b0; m_clr <= 1'b0; m_match <= 1'b0; m_int <= 1'b0;
            m_pen <= 1'b0; m_pval <= '0; m_since <= 0; m_cnt <= '0;
        end else begin
            m_run   <= n_run;
            m_halt  <= n_halt;
            m_clr   <= m_run && !timer_en;
            m_since <= n_since;
            m_pen   <= div_en;
            m_pval  <= div_val;
            m_match <= (m_cnt == cmp);
            m_int   <= m_match || (m_int && !int_st_clr);
            if (load)            m_cnt <= load_val;
            else if (m_clr)      m_cnt <= '0;
            else if (exp_cnt_en) m_cnt <= m_cnt + 64'd1;
        end
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        timer_en = 1'b1; int_en = 1'b1; cmp = '0;
        for (int k = 0; k < 3; k++) begin
            cyc();
            checks++; if (cnt_en !== 1'b0)   begin errors++; $display("FAIL reset cnt_en: got %b want 0", cnt_en); end
            checks++; if (cnt_clr !== 1'b0)  begin errors++; $display("FAIL reset cnt_clr: got %b want 0", cnt_clr); end
            checks++; if (halt_ack !== 1'b0) begin errors++; $display("FAIL reset halt_ack: got %b want 0", halt_ack); end
            checks++; if (int_st !== 1'b0)   begin errors++; $display("FAIL reset int_st: got %b want 0", int_st); end
            checks++; if (tim_int !== 1'b0)  begin errors++; $display("FAIL reset tim_int: got %b want 0", tim_int); end
        end
        timer_en = 1'b0; int_en = 1'b0; cmp = '1; rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc();
            checks++; if (cnt_clr !== 1'b0) begin errors++; $display("FAIL post_reset cnt_clr: got %b want 0", cnt_clr); end
            checks++; if (cnt_en !== 1'b0)  begin errors++; $display("FAIL post_reset cnt_en: got %b want 0", cnt_en); end
        end
    endtask

    task automatic test_no_div();
        div_en = 1'b0; timer_en = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            cyc();
            checks++; if (cnt_en !== 1'b1) begin errors++; $display("FAIL no_div cnt_en cycle %0d: got %b want 1", k, cnt_en); end
            checks++; if (cnt !== 64'(k - 1)) begin errors++; $display("FAIL no_div cnt cycle %0d: got %0h want %0h", k, cnt, k - 1); end
        end
        timer_en = 1'b0;
        cyc();
        checks++; if (cnt_clr !== 1'b1) begin errors++; $display("FAIL no_div clr pulse: got %b want 1", cnt_clr); end
        cyc();
        checks++; if (cnt_clr !== 1'b0) begin errors++; $display("FAIL no_div clr width: got %b want 0", cnt_clr); end
        checks++; if (cnt !== 64'd0)    begin errors++; $display("FAIL no_div cleared cnt: got %0h want 0", cnt); end
    endtask

    task automatic test_prescale();
        int pulses;
        div_en = 1'b1; div_val = 4'd2;
        cyc(); cyc();
        timer_en = 1'b1;
        pulses = 0;
        for (int k = 1; k <= 14; k++) begin
            cyc();
            if (cnt_en === 1'b1) pulses++;
            checks++; if (cnt_en !== ((k % 4) == 0)) begin errors++; $display("FAIL div4 cnt_en cycle %0d: got %b want %b", k, cnt_en, (k % 4) == 0); end
        end
        checks++; if (pulses != 3) begin errors++; $display("FAIL div4 pulse count: got %0d want 3", pulses); end
        div_val = 4'd3;
        for (int j = 1; j <= 15; j++) begin
            cyc();
            checks++; if (cnt_en !== (j == 8)) begin errors++; $display("FAIL div8 restart cycle %0d: got %b want %b", j, cnt_en, j == 8); end
        end
        div_val = 4'd12;
        for (int j = 1; j <= 512; j++) begin
            cyc();
            checks++; if (cnt_en !== ((j % 256) == 0)) begin errors++; $display("FAIL div_clamp cycle %0d: got %b want %b", j, cnt_en, (j % 256) == 0); end
        end
        timer_en = 1'b0; div_en = 1'b0; div_val = 4'd0;
        cyc(); cyc();
    endtask

    task automatic test_interrupt();
        int seen;
        cmp = 64'h0000_0001_0000_0005; load = 1'b1; load_val = 64'h0000_0001_0000_0000; int_en = 1'b1;
        cyc();
        load = 1'b0; timer_en = 1'b1;
        seen = -1;
        for (int k = 1; k <= 20; k++) begin
            cyc();
            if (seen < 0 && cnt === cmp) seen = k;
            checks++; if (int_st !== (seen >= 0 && k >= seen + 2)) begin errors++; $display("FAIL irq int_st cycle %0d: got %b want %b", k, int_st, seen >= 0 && k >= seen + 2); end
            checks++; if (tim_int !== (seen >= 0 && k >= seen + 2)) begin errors++; $display("FAIL irq tim_int cycle %0d: got %b want %b", k, tim_int, seen >= 0 && k >= seen + 2); end
        end
        checks++; if (seen != 6) begin errors++; $display("FAIL irq match cycle: got %0d want 6", seen); end
        int_en = 1'b0;
        #1;
        checks++; if (tim_int !== 1'b0) begin errors++; $display("FAIL irq mask tim_int: got %b want 0", tim_int); end
        checks++; if (int_st !== 1'b1)  begin errors++; $display("FAIL irq mask int_st: got %b want 1", int_st); end
        int_en = 1'b1;
        #1;
        checks++; if (tim_int !== 1'b1) begin errors++; $display("FAIL irq unmask tim_int: got %b want 1", tim_int); end
        cyc();
        int_st_clr = 1'b1;
        cyc();
        int_st_clr = 1'b0;
        checks++; if (int_st !== 1'b0) begin errors++; $display("FAIL irq clear int_st: got %b want 0", int_st); end
        timer_en = 1'b0;
        cyc(); cyc();
        load = 1'b1; load_val = cmp;
        cyc();
        load = 1'b0;
        cyc(); cyc(); cyc();
        checks++; if (int_st !== 1'b1) begin errors++; $display("FAIL irq idle match int_st: got %b want 1", int_st); end
        int_st_clr = 1'b1;
        cyc();
        int_st_clr = 1'b0;
        checks++; if (int_st !== 1'b1) begin errors++; $display("FAIL irq clear while matching: got %b want 1", int_st); end
        cmp = '1;
        cyc();
        int_st_clr = 1'b1;
        cyc();
        int_st_clr = 1'b0;
        checks++; if (int_st !== 1'b0) begin errors++; $display("FAIL irq clear after match: got %b want 0", int_st); end
        load = 1'b1; load_val = '0;
        cyc();
        load = 1'b0;
    endtask

    task automatic test_halt();
        logic [63:0] c0, c1;
        div_en = 1'b0; dbg_mode = 1'b1; timer_en = 1'b1;
        cyc(); cyc(); cyc();
        c0 = cnt;
        halt_req = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            cyc();
            checks++; if (halt_ack !== 1'b1)   begin errors++; $display("FAIL halt ack cycle %0d: got %b want 1", k, halt_ack); end
            checks++; if (cnt_en !== 1'b0)     begin errors++; $display("FAIL halt cnt_en cycle %0d: got %b want 0", k, cnt_en); end
            checks++; if (cnt !== c0 + 64'd1)  begin errors++; $display("FAIL halt cnt hold cycle %0d: got %0h want %0h", k, cnt, c0 + 64'd1); end
        end
        halt_req = 1'b0;
        cyc();
        checks++; if (halt_ack !== 1'b0) begin errors++; $display("FAIL halt release ack: got %b want 0", halt_ack); end
        checks++; if (cnt_en !== 1'b1)   begin errors++; $display("FAIL halt release cnt_en: got %b want 1", cnt_en); end
        dbg_mode = 1'b0; halt_req = 1'b1;
        for (int j = 1; j <= 5; j++) begin
            cyc();
            checks++; if (halt_ack !== 1'b0) begin errors++; $display("FAIL nodbg ack cycle %0d: got %b want 0", j, halt_ack); end
            checks++; if (cnt !== c0 + 64'(1 + j)) begin errors++; $display("FAIL nodbg cnt cycle %0d: got %0h want %0h", j, cnt, c0 + 64'(1 + j)); end
        end
        dbg_mode = 1'b1;
        cyc();
        c1 = cnt;
        cyc();
        checks++; if (halt_ack !== 1'b1) begin errors++; $display("FAIL halt2 ack: got %b want 1", halt_ack); end
        checks++; if (cnt !== c1)        begin errors++; $display("FAIL halt2 cnt hold: got %0h want %0h", cnt, c1); end
        timer_en = 1'b0;
        cyc();
        checks++; if (cnt_clr !== 1'b1)  begin errors++; $display("FAIL halt stop clr: got %b want 1", cnt_clr); end
        checks++; if (halt_ack !== 1'b0) begin errors++; $display("FAIL halt stop ack: got %b want 0", halt_ack); end
        cyc();
        checks++; if (cnt_clr !== 1'b0) begin errors++; $display("FAIL halt stop clr width: got %b want 0", cnt_clr); end
        checks++; if (cnt !== 64'd0)    begin errors++; $display("FAIL halt stop cnt: got %0h want 0", cnt); end
        halt_req = 1'b0; dbg_mode = 1'b0;
    endtask

    task automatic test_stop();
        timer_en = 1'b1;
        cyc(); cyc();
        load = 1'b1; load_val = 64'h1234;
        cyc();
        load = 1'b0;
        checks++; if (cnt !== 64'h1234) begin errors++; $display("FAIL stop preload: got %0h want 1234", cnt); end
        timer_en = 1'b0;
        cyc();
        checks++; if (cnt_clr !== 1'b1) begin errors++; $display("FAIL stop clr: got %b want 1", cnt_clr); end
        cyc();
        checks++; if (cnt_clr !== 1'b0) begin errors++; $display("FAIL stop clr width: got %b want 0", cnt_clr); end
        checks++; if (cnt !== 64'd0)    begin errors++; $display("FAIL stop cnt: got %0h want 0", cnt); end
        checks++; if (cnt_en !== 1'b0)  begin errors++; $display("FAIL stop idle cnt_en: got %b want 0", cnt_en); end
        cyc();
        checks++; if (cnt_clr !== 1'b0) begin errors++; $display("FAIL stop idle clr: got %b want 0", cnt_clr); end
    endtask

    task automatic test_async_reset();
        cmp = 64'd3; int_en = 1'b1; timer_en = 1'b1;
        repeat (8) cyc();
        checks++; if (int_st !== 1'b1) begin errors++; $display("FAIL areset setup int_st: got %b want 1", int_st); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (int_st !== 1'b0)   begin errors++; $display("FAIL areset int_st: got %b want 0", int_st); end
        checks++; if (tim_int !== 1'b0)  begin errors++; $display("FAIL areset tim_int: got %b want 0", tim_int); end
        checks++; if (cnt_en !== 1'b0)   begin errors++; $display("FAIL areset cnt_en: got %b want 0", cnt_en); end
        checks++; if (halt_ack !== 1'b0) begin errors++; $display("FAIL areset halt_ack: got %b want 0", halt_ack); end
        cyc(); cyc();
        timer_en = 1'b0; cmp = '1; rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc();
            checks++; if (cnt_en !== 1'b0)  begin errors++; $display("FAIL areset idle cnt_en: got %b want 0", cnt_en); end
            checks++; if (cnt_clr !== 1'b0) begin errors++; $display("FAIL areset idle clr: got %b want 0", cnt_clr); end
        end
        timer_en = 1'b1;
        cyc();
        checks++; if (cnt_en !== 1'b1) begin errors++; $display("FAIL areset restart cnt_en: got %b want 1", cnt_en); end
        timer_en = 1'b0;
        cyc(); cyc();
    endtask

    task automatic test_random();
        timer_en = 1'b1; int_en = 1'b1; dbg_mode = 1'b0; halt_req = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            cyc();
            checks++; if (cnt_en !== exp_cnt_en) begin errors++; $display("FAIL rnd cnt_en cycle %0d: got %b want %b", n, cnt_en, exp_cnt_en); end
            checks++; if (cnt_clr !== m_clr)     begin errors++; $display("FAIL rnd cnt_clr cycle %0d: got %b want %b", n, cnt_clr, m_clr); end
            checks++; if (halt_ack !== m_halt)   begin errors++; $display("FAIL rnd halt_ack cycle %0d: got %b want %b", n, halt_ack, m_halt); end
            checks++; if (int_st !== m_int)      begin errors++; $display("FAIL rnd int_st cycle %0d: got %b want %b", n, int_st, m_int); end
            checks++; if (tim_int !== (m_int & int_en)) begin errors++; $display("FAIL rnd tim_int cycle %0d: got %b want %b", n, tim_int, m_int & int_en); end
            checks++; if (cnt !== m_cnt)         begin errors++; $display("FAIL rnd cnt cycle %0d: got %0h want %0h", n, cnt, m_cnt); end
            if ($urandom_range(0, 39) == 0) timer_en = ~timer_en;
            if ($urandom_range(0, 63) == 0) div_en = ~div_en;
            if ($urandom_range(0, 63) == 0)
                div_val = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) dbg_mode = ~dbg_mode;
            if ($urandom_range(0, 9) == 0)  halt_req = ~halt_req;
            if ($urandom_range(0, 19) == 0) int_en = ~int_en;
            int_st_clr = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 29) == 0) cmp = cnt + 64'($urandom_range(0, 12));
        end
        int_st_clr = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_no_div();
        test_prescale();
        test_interrupt();
        test_halt();
        test_stop();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/timer_ctrl.md
# timer_ctrl

Control and interrupt sequencer for the Timer's 64-bit up-counter. It derives the counter's `cnt_en` from a programmable power-of-two prescaler, and issues `cnt_clr` when the timer is disabled. It freezes counting on a debug halt request. It compares the live count against a 64-bit compare value to raise a sticky, maskable interrupt. It sits between the register block, which supplies control fields, and the counter datapath, which consumes `cnt_en`/`cnt_clr` and returns `cnt`.

## Interface
- `DIV_MAX`, default 8: largest honoured prescaler exponent. Any `div_val` above it is treated as `DIV_MAX`.
- `clk` input 1: single system clock. All logic is on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `timer_en` input 1: level. 1 = timer counting enabled.
- `div_en` input 1: level. 1 = prescaler active.
- `div_val` input 4: prescaler exponent. Divisor = 2^`div_val`.
- `dbg_mode` input 1: level. Debug halt requests are honoured only when this is 1.
- `halt_req` input 1: level. Debug halt request.
- `cmp` input 64: compare value, `{TCMP1, TCMP0}`.
- `int_en` input 1: interrupt enable (mask).
- `int_st_clr` input 1: single-cycle pulse. Write-1-to-clear of the interrupt status.
- `cnt` input 64: live counter value from the counter datapath.
- `cnt_en` output 1: increment strobe to the counter.
- `cnt_clr` output 1: single-cycle clear strobe to the counter.
- `halt_ack` output 1: high while the block is in HALT.
- `int_st` output 1: sticky interrupt status.
- `tim_int` output 1: interrupt line, `int_st & int_en`.

## Operation
- The state machine has three states: IDLE, RUN and HALT. Reset puts it in IDLE.
  - IDLE to RUN: `timer_en`=1.
  - RUN to IDLE: `timer_en`=0.
  - RUN to HALT: `dbg_mode`=1 and `halt_req`=1.
  - HALT to RUN: `halt_req`=0 or `dbg_mode`=0, with `timer_en`=1.
  - HALT to IDLE: `timer_en`=0. This takes priority over the halt release.
- Effective exponent: `e` = min(`div_val`, `DIV_MAX`) when `div_en`=1, otherwise 0.
- The prescaler is an internal counter `pcnt` of `DIV_MAX` bits.
  - `tick` = 1 when `e`=0, or when `pcnt` == 2^`e`−1.
  - In RUN, `pcnt` increments every cycle and wraps to 0 on `tick`.
  - In HALT, `pcnt` holds.
  - In IDLE, `pcnt` is 0.
- If `div_en` or `div_val` differs from its value on the previous cycle, `pcnt` is forced to 0 that cycle and no `tick` is issued. This restarts the divide period.
- `cnt_en` = (state == RUN) & `tick`. It is combinational from registered state, `pcnt` and the divider fields.
- `cnt_clr` pulses for one cycle in the cycle after a RUN/HALT to IDLE transition, i.e. after `timer_en` falls. No pulse is issued at reset or while staying in IDLE.
- Compare path:
  - `match_q` registers (`cnt` == `cmp`) every cycle, in every state.
  - `int_st` is set on `match_q`=1.
  - `int_st` is cleared on `int_st_clr`=1.
  - If both happen in the same cycle, set wins.
  - Because `match_q` is re-evaluated every cycle, a clear is ineffective while the count still equals `cmp`. This case arises when halted, in IDLE, or with a slow prescaler.
- Reset values: state IDLE, `pcnt`=0, `match_q`=0, `int_st`=0. All outputs are therefore 0 during and after reset.

## Timing
- The cycle after `timer_en` rises (sampled in IDLE), the state is RUN. With `e`=0, the first `cnt_en`=1 occurs in that cycle, so `cnt` reads 1 one cycle later.
- With `e`=k>0 and steady divider fields, `cnt_en` is high for 1 cycle in every 2^k. The first pulse comes 2^k cycles after entering RUN.
- Halt entry: `halt_ack` rises and `cnt_en` is forced low in the cycle after `halt_req` is sampled high. Release takes one cycle, and the prescaler resumes from its held phase.
- `int_st` latency: 2 cycles from the clock edge on which `cnt` becomes equal to `cmp`: one cycle to `match_q`, one to `int_st`. `tim_int` follows `int_st` combinationally.
- Changing `int_en` affects `tim_int` in the same cycle. It never modifies `int_st`.
- Asynchronous reset mid-count: all outputs drop immediately. Any `cnt_clr` in progress is lost; the counter's own reset covers this.

## Test plan
- `div_en`=0, `timer_en` raised at cycle 0: `cnt_en`=1 every cycle from cycle 1, and `cnt` reaches 10 at cycle 11.
- `div_en`=1, `div_val`=2: `cnt_en` pulses exactly every 4 cycles. `div_val` changed to 3 mid-run: the phase restarts, with the next pulse 8 cycles after the change. `div_val`=12 behaves as 8 (256-cycle period).
- `cmp`=0x0000_0001_0000_0005, counter preloaded to 0x0000_0001_0000_0000, `int_en`=1: `tim_int` rises 2 cycles after `cnt` = `cmp`. It stays high after `cnt` moves past `cmp` until an `int_st_clr` pulse. `int_st_clr` asserted while `match_q`=1 leaves `int_st`=1.
- `dbg_mode`=1, `halt_req` held 5 cycles during RUN: `halt_ack`=1 and `cnt_en`=0 for those cycles, and `cnt` holds. With `dbg_mode`=0 the same request has no effect.
- `timer_en` dropped while `cnt`=0x1234: `cnt_clr`=1 for exactly one cycle, `cnt` becomes 0, and the state returns to IDLE. `timer_en` dropped while in HALT gives the same result.
- `rst_n` asserted mid-run with `int_st`=1: `int_st`, `tim_int`, `cnt_en` and `halt_ack` go to 0 asynchronously. After release, the block stays in IDLE until `timer_en` is re-sampled high.
